// File: rtl/data_bus_ctrl_pkg.sv
// Shared definitions for the data-side bus controller.
// Holds the default bus width, the controller state and decode-region
// enumerations, and the default peripheral addresses.
package data_bus_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [15:0] LED_ADDR_DFLT = 16'h1000;
  localparam logic [15:0] SW_ADDR_DFLT  = 16'h3000;

  typedef enum logic {
    IDLE,
    WAIT
  } bus_state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_NONE
  } region_t;

endpackage

// File: rtl/data_bus_ctrl_ram.sv
// Single-port data RAM: synchronous write, asynchronous read.
// Ports:
//   clk   - write clock
//   we    - write enable, sampled at the rising edge
//   addr  - word address
//   wdata - write data
//   rdata - combinational read data at addr
module data_ram #(
  parameter int WORD_SIZE = 16,
  parameter int RAM_WORDS = 256,
  localparam int AW = $clog2(RAM_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_bus_ctrl.sv
// Data-side bus controller behind the processor's Memory stage.
// Decodes each data-port access to the on-chip RAM, the LED register or the
// switch port, stretches RAM accesses by RAM_WAIT wait states and flags
// protocol/decode errors on a sticky BusErr.
// Ports:
//   Clock, Resetn      - clock (rising edge), async active-low reset
//   DataAddr, DataOut  - word address and write data from the processor
//   ReadData/WriteData - read / write requests (held while DataWaitreq=1)
//   DataIn             - read data, 0 unless a read completes this cycle
//   DataWaitreq        - combinational stall request
//   SW, LEDR           - switch inputs (asynchronous) and LED register
//   BusErr             - sticky error flag, cleared only by reset
module data_bus_ctrl #(
  parameter int                   WORD_SIZE = data_bus_ctrl_pkg::WORD_SIZE,
  parameter int                   RAM_WORDS = 256,
  parameter int                   RAM_WAIT  = 2,
  parameter logic [WORD_SIZE-1:0] LED_ADDR  = WORD_SIZE'(data_bus_ctrl_pkg::LED_ADDR_DFLT),
  parameter logic [WORD_SIZE-1:0] SW_ADDR   = WORD_SIZE'(data_bus_ctrl_pkg::SW_ADDR_DFLT),
  parameter int                   LED_BITS  = 10,
  parameter int                   SW_BITS   = 10
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  input  logic [SW_BITS-1:0]   SW,
  output logic [LED_BITS-1:0]  LEDR,
  output logic                 BusErr
);
  import data_bus_ctrl_pkg::*;

  localparam int AW = $clog2(RAM_WORDS);

  bus_state_t           state;
  logic [3:0]           cnt;
  logic [SW_BITS-1:0]   sw_meta_p0;
  logic [SW_BITS-1:0]   sw_sync_p1;
  region_t              region;
  logic                 req;
  logic                 ram_done;
  logic                 ram_we;
  logic [WORD_SIZE-1:0] ram_rdata;

  assign req = ReadData | WriteData;

  always_comb begin
    region = REG_NONE;
    if (DataAddr < WORD_SIZE'(RAM_WORDS)) region = REG_RAM;
    else if (DataAddr == LED_ADDR)        region = REG_LED;
    else if (DataAddr == SW_ADDR)         region = REG_SW;
  end

  // Stall, completion and read-data mux. Everything is gated by Resetn so the
  // outputs read as idle while reset is held, even with a request pending.
  // A simultaneous read+write is a write, so it never returns read data.
  always_comb begin
    DataWaitreq = 1'b0;
    ram_done    = 1'b0;
    DataIn      = '0;
    if (Resetn && req) begin
      if (state == IDLE) begin
        if (region == REG_RAM) begin
          if (RAM_WAIT == 0) ram_done    = 1'b1;
          else               DataWaitreq = 1'b1;
        end
      end else begin
        if (cnt != 4'd0) DataWaitreq = 1'b1;
        else             ram_done    = 1'b1;
      end

      if (ram_done && !WriteData) begin
        DataIn = ram_rdata;
      end else if (state == IDLE && ReadData && !WriteData) begin
        if (region == REG_LED)     DataIn = WORD_SIZE'(LEDR);
        else if (region == REG_SW) DataIn = WORD_SIZE'(sw_sync_p1);
      end
    end
  end

  assign ram_we = ram_done & WriteData;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      LEDR       <= '0;
      BusErr     <= 1'b0;
      sw_meta_p0 <= '0;
      sw_sync_p1 <= '0;
    end else begin
      // Switch synchronizer stage boundary
      sw_meta_p0 <= SW;
      sw_sync_p1 <= sw_meta_p0;

      if (req && ReadData && WriteData) BusErr <= 1'b1;

      case (state)
        IDLE: begin
          if (req) begin
            case (region)
              REG_RAM: begin
                if (RAM_WAIT > 0) begin
                  state <= WAIT;
                  cnt   <= 4'(RAM_WAIT - 1);
                end
              end
              REG_LED:  if (WriteData) LEDR <= DataOut[LED_BITS-1:0];
              REG_SW:   ;
              default:  BusErr <= 1'b1;
            endcase
          end
        end
        WAIT: begin
          if (!req) begin
            // Processor abandoned the access: nothing is written.
            state  <= IDLE;
            BusErr <= 1'b1;
          end else if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  data_ram #(
    .WORD_SIZE (WORD_SIZE),
    .RAM_WORDS (RAM_WORDS)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .addr  (DataAddr[AW-1:0]),
    .wdata (DataOut),
    .rdata (ram_rdata)
  );

endmodule
